// File: rtl/spi_mosi_ctrl.sv
// Transaction controller and arbiter sharing one spi_mosi byte shifter between NREQ requesters.
// Define SPI_ARB_FIXED_PRIO_EN for fixed lowest-index priority; the default build is round-robin.
//
// state | meaning
// IDLE  | cs high, waiting for any req, picks the winner
// LOAD  | one cycle: present winner's byte, data_av + byte_ack pulse
// SHIFT | cs low for 8 cycles while the shifter clocks the byte out
// GAP   | cs high for CS_GAP cycles, grant released
module spi_mosi_ctrl #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16,
  parameter int CS_GAP    = 2
) (
  input  logic                spi_clk,
  input  logic                spi_rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     grant,
  output logic [NREQ-1:0]     byte_ack,
  output logic                spi_cs,
  output logic                data_av,
  output logic [7:0]          spi_mosi_in,
  output logic                busy
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int GW = $clog2(CS_GAP + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   arb_idx;
  logic            arb_vld;
  logic [2:0]      bit_q, bit_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            last_q, last_d;
  logic [7:0]      mosi_q, mosi_d;
  logic [NREQ-1:0] win_oh;

  assign win_oh = NREQ'(1) << win_q;

`ifdef SPI_ARB_FIXED_PRIO_EN
  always_comb begin
    arb_vld = 1'b0;
    arb_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        arb_vld = 1'b1;
        arb_idx = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] rr_q, rr_d;
  logic [IW:0]   cand;

  // Descending scan so the candidate nearest rr_q+1 is assigned last and wins.
  always_comb begin
    arb_vld = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = {1'b0, rr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (req[cand[IW-1:0]]) begin
        arb_vld = 1'b1;
        arb_idx = cand[IW-1:0];
      end
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    bit_d       = bit_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    last_d      = last_q;
    mosi_d      = mosi_q;
`ifndef SPI_ARB_FIXED_PRIO_EN
    rr_d        = rr_q;
`endif
    spi_cs      = 1'b1;
    data_av     = 1'b0;
    spi_mosi_in = mosi_q;
    grant       = '0;
    byte_ack    = '0;
    busy        = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (arb_vld) begin
          win_d   = arb_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        grant       = win_oh;
        byte_ack    = win_oh;
        data_av     = 1'b1;
        spi_mosi_in = req_data[{win_q, 3'b000} +: 8];
        mosi_d      = req_data[{win_q, 3'b000} +: 8];
        last_d      = req_last[win_q];
        cnt_d       = cnt_q + BW'(1);
        bit_d       = 3'd0;
        // CS stays low between bytes of a burst; only the first LOAD sees it high.
        spi_cs      = (cnt_q == '0);
        state_d     = SHIFT;
      end
      SHIFT: begin
        grant  = win_oh;
        spi_cs = 1'b0;
        bit_d  = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          if (last_q || cnt_q == BW'(MAX_BURST) || !req[win_q]) begin
            gap_d   = GW'(CS_GAP - 1);
            state_d = GAP;
          end else begin
            state_d = LOAD;
          end
        end
      end
      GAP: begin
        cnt_d = '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
        rr_d  = win_q;
`endif
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
    endcase
  end

  always_ff @(posedge spi_clk) begin
    if (!spi_rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      last_q  <= 1'b0;
      mosi_q  <= 8'h00;
`ifndef SPI_ARB_FIXED_PRIO_EN
      rr_q    <= IW'(NREQ - 1);
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      mosi_q  <= mosi_d;
`ifndef SPI_ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_mosi_ctrl.sv
// Directed bench for spi_mosi_ctrl (NREQ=4, MAX_BURST=4, CS_GAP=2); outputs sampled on negedge.
module tb_spi_mosi_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, req_last, grant, byte_ack;
  logic [31:0] req_data;
  logic        spi_cs, data_av, busy;
  logic [7:0]  mosi;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  spi_mosi_ctrl #(.NREQ(4), .MAX_BURST(4), .CS_GAP(2)) dut (
    .spi_clk    (clk),
    .spi_rst_n  (rst_n),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .grant      (grant),
    .byte_ack   (byte_ack),
    .spi_cs     (spi_cs),
    .data_av    (data_av),
    .spi_mosi_in(mosi),
    .busy       (busy)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = '0; req_data = '0; req_last = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    checks++; if (spi_cs !== 1'b1) begin errors++; $display("FAIL reset_cs got %b exp 1", spi_cs); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b exp 0000", grant); end
    checks++; if (byte_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b exp 0000", byte_ack); end
    checks++; if (data_av !== 1'b0) begin errors++; $display("FAIL reset_data_av got %b exp 0", data_av); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (mosi !== 8'h00) begin errors++; $display("FAIL reset_mosi got %h exp 00", mosi); end
    // start a byte, then reset while bit 3 is shifting
    req = 4'b0001; req_data[7:0] = 8'h3C; req_last = 4'b0001;
    tick();
    req = 4'b0000;
    repeat (4) tick();
    checks++; if (spi_cs !== 1'b0) begin errors++; $display("FAIL midshift_cs got %b exp 0", spi_cs); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (spi_cs !== 1'b1) begin errors++; $display("FAIL abort_cs got %b exp 1", spi_cs); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL abort_grant got %b exp 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    checks++; if (byte_ack !== 4'b0000) begin errors++; $display("FAIL abort_ack got %b exp 0000", byte_ack); end
    checks++; if (mosi !== 8'h00) begin errors++; $display("FAIL abort_mosi got %h exp 00", mosi); end
    repeat (3) begin
      tick();
      checks++;
      if (byte_ack !== 4'b0000 || busy !== 1'b0) begin
        errors++; $display("FAIL abort_quiet ack=%b busy=%b exp 0000/0", byte_ack, busy);
      end
    end
  endtask

  task automatic test_single;
    bit ok;
    req = 4'b0001; req_data[7:0] = 8'h0C; req_last = 4'b0001;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant got %b exp 0001", grant); end
    checks++; if (data_av !== 1'b1) begin errors++; $display("FAIL single_data_av got %b exp 1", data_av); end
    checks++; if (mosi !== 8'h0C) begin errors++; $display("FAIL single_mosi got %h exp 0c", mosi); end
    checks++; if (byte_ack !== 4'b0001) begin errors++; $display("FAIL single_ack got %b exp 0001", byte_ack); end
    checks++; if (spi_cs !== 1'b1) begin errors++; $display("FAIL single_load_cs got %b exp 1", spi_cs); end
    req = 4'b0000; req_last = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (spi_cs !== 1'b0 || data_av !== 1'b0 || mosi !== 8'h0C) begin
        errors++; $display("FAIL single_shift%0d cs=%b dav=%b mosi=%h exp 0/0/0c", i, spi_cs, data_av, mosi);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (spi_cs !== 1'b1 || busy !== 1'b1 || grant !== 4'b0000) begin
        errors++; $display("FAIL single_gap%0d cs=%b busy=%b grant=%b exp 1/1/0000", i, spi_cs, busy, grant);
      end
    end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle busy=%b exp 0", busy); end
    wait_idle(ok);
  endtask

  task automatic test_burst;
    logic [7:0] bytes [3];
    int nack = 0, last_ack = 0, run = 0, max_run = 0, cyc = 0;
    bit upd = 0, started = 0, ok;
    bytes[0] = 8'h01; bytes[1] = 8'hA5; bytes[2] = 8'hFF;
    req_data[15:8] = bytes[0]; req_last = 4'b0000; req = 4'b0010;
    while (cyc < 80 && !(started && busy === 1'b0)) begin
      tick(); cyc++;
      if (upd) begin
        upd = 0;
        if (nack < 3) begin req_data[15:8] = bytes[nack]; req_last[1] = (nack == 2); end
        else begin req = 4'b0000; req_last = 4'b0000; end
      end
      if (busy === 1'b1) started = 1;
      if (spi_cs === 1'b0) begin run++; if (run > max_run) max_run = run; end
      else run = 0;
      if (byte_ack[1] === 1'b1) begin
        if (nack < 3) begin
          checks++; if (mosi !== bytes[nack]) begin errors++; $display("FAIL burst_byte%0d got %h exp %h", nack, mosi, bytes[nack]); end
        end
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL burst_grant got %b exp 0010", grant); end
        if (nack > 0) begin
          checks++; if (cyc - last_ack !== 9) begin errors++; $display("FAIL burst_spacing got %0d exp 9", cyc - last_ack); end
        end
        last_ack = cyc; nack++; upd = 1;
      end
    end
    checks++; if (nack !== 3) begin errors++; $display("FAIL burst_ack_count got %0d exp 3", nack); end
    checks++; if (max_run !== 26) begin errors++; $display("FAIL burst_cs_low got %0d exp 26", max_run); end
    req = 4'b0000;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_idle timeout busy=%b exp 0", busy); end
  endtask

  task automatic test_rr;
    logic [3:0] exp_g [4];
    logic [7:0] exp_d [4];
    int nack = 0, cyc = 0;
    bit ok;
`ifdef SPI_ARB_FIXED_PRIO_EN
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0001; exp_g[2] = 4'b0001; exp_g[3] = 4'b0001;
`else
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0100; exp_g[2] = 4'b0001; exp_g[3] = 4'b0100;
`endif
    for (int i = 0; i < 4; i++) exp_d[i] = (exp_g[i] == 4'b0001) ? 8'h10 : 8'h20;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req_data[7:0] = 8'h10; req_data[23:16] = 8'h20; req_last = 4'b0101; req = 4'b0101;
    while (cyc < 120 && nack < 4) begin
      tick(); cyc++;
      if (byte_ack !== 4'b0000) begin
        checks++; if (grant !== exp_g[nack]) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", nack, grant, exp_g[nack]); end
        checks++; if (byte_ack !== exp_g[nack]) begin errors++; $display("FAIL rr_ack%0d got %b exp %b", nack, byte_ack, exp_g[nack]); end
        checks++; if (mosi !== exp_d[nack]) begin errors++; $display("FAIL rr_mosi%0d got %h exp %h", nack, mosi, exp_d[nack]); end
        nack++;
        if (nack == 4) req = 4'b0000;
      end
    end
    req = 4'b0000; req_last = 4'b0000;
    checks++; if (nack !== 4) begin errors++; $display("FAIL rr_count got %0d exp 4", nack); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_idle timeout busy=%b exp 0", busy); end
  endtask

  task automatic test_max_burst;
    int n3 = 0, t3 = 0, cyc = 0;
    bit got1 = 0, ok;
    req_data[31:24] = 8'h33; req_data[15:8] = 8'h11; req_last = 4'b0010; req = 4'b1000;
    while (cyc < 150 && !got1) begin
      tick(); cyc++;
      if (byte_ack[3] === 1'b1) begin
        n3++; t3 = cyc;
        if (n3 == 1) req[1] = 1'b1;
      end
      if (byte_ack[1] === 1'b1) begin
        got1 = 1;
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL maxb_grant got %b exp 0010", grant); end
        checks++; if (cyc - t3 !== 12) begin errors++; $display("FAIL maxb_release_gap got %0d exp 12", cyc - t3); end
        req = 4'b0000;
      end
    end
    req = 4'b0000;
    checks++; if (n3 !== 4) begin errors++; $display("FAIL maxb_ack3_count got %0d exp 4", n3); end
    checks++; if (!got1) begin errors++; $display("FAIL maxb_req1_grant got none exp 0010"); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL maxb_idle timeout busy=%b exp 0", busy); end
    req_last = 4'b0000;
  endtask

  task automatic test_drop;
    int nack = 0, run = 0, max_run = 0, cyc = 0;
    bit upd = 0, started = 0, ok;
    req_data[23:16] = 8'h51; req_last = 4'b0000; req = 4'b0100;
    while (cyc < 80 && !(started && busy === 1'b0)) begin
      tick(); cyc++;
      if (upd) begin
        upd = 0;
        if (nack == 1) req_data[23:16] = 8'h52;
        else req = 4'b0000;
      end
      if (busy === 1'b1) started = 1;
      if (spi_cs === 1'b0) begin run++; if (run > max_run) max_run = run; end
      else run = 0;
      if (byte_ack[2] === 1'b1) begin nack++; upd = 1; end
    end
    req = 4'b0000;
    checks++; if (nack !== 2) begin errors++; $display("FAIL drop_ack_count got %0d exp 2", nack); end
    checks++; if (max_run !== 17) begin errors++; $display("FAIL drop_cs_low got %0d exp 17", max_run); end
    checks++; if (mosi !== 8'h52) begin errors++; $display("FAIL drop_mosi_held got %h exp 52", mosi); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_idle timeout busy=%b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_rr();
    test_max_burst();
    test_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
